// File: rtl/onehot_to_bin_pipe_pkg.sv
// Shared constants and helpers for the pipelined one-hot to binary encoder.
package onehot_to_bin_pipe_pkg;

  localparam int W_DEF = 4;
  localparam int N_DEF = 1 << W_DEF;

  // Width of the vector a fold level hands to the next level (level m outputs 2**m bits).
  function automatic int fold_width(input int m);
    return 1 << m;
  endfunction

endpackage

// File: rtl/onehot_to_bin_pipe_if.sv
// Request/result bundle of the one-hot encoder; master drives the code, slave returns the index.
interface onehot_to_bin_pipe_if
  import onehot_to_bin_pipe_pkg::*;
#(
  parameter int W = W_DEF
) ();

  localparam int N = fold_width(W);

  logic         in_vld;
  logic [N-1:0] onehot;
  logic         out_vld;
  logic [W-1:0] bin;
  logic         err;

  modport master (output in_vld, onehot, input out_vld, bin, err);
  modport slave  (input in_vld, onehot, output out_vld, bin, err);

endinterface

// File: rtl/bin_to_onehot_shift.sv
// Combinational binary to one-hot decoder used to generate encoder stimulus.
module bin_to_onehot_shift
  import onehot_to_bin_pipe_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0]             bin,
  output logic [fold_width(W)-1:0] onehot
);

  localparam int N = fold_width(W);

  assign onehot = N'(1) << bin;

endmodule

// File: rtl/onehot_to_bin_pipe_fold_stage.sv
// One fold level: halves the vector, records bin[M] from the upper half and
// accumulates the multi-hot flag from overlapping halves.
module onehot_fold_stage
  import onehot_to_bin_pipe_pkg::*;
#(
  parameter int M = 0,
  parameter int W = W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2*fold_width(M)-1:0] vec,
  input  logic [W-1:0]               bin,
  input  logic                       multi,
  input  logic                       vld,
  output logic [fold_width(M)-1:0]   vec_q,
  output logic [W-1:0]               bin_q,
  output logic                       multi_q,
  output logic                       vld_q
);

  localparam int H = fold_width(M);

  logic [H-1:0] lo;
  logic [H-1:0] hi;
  logic [W-1:0] bin_next;

  assign lo       = vec[H-1:0];
  assign hi       = vec[2*H-1:H];
  assign bin_next = bin | (W'(|hi) << M);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q   <= '0;
      bin_q   <= '0;
      multi_q <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      vec_q   <= lo | hi;
      bin_q   <= bin_next;
      multi_q <= multi | (|(lo & hi));
      vld_q   <= vld;
    end
  end

endmodule

// File: rtl/onehot_to_bin_pipe.sv
// W-level registered fold tree converting a 2**W-bit one-hot code to its index,
// one result per cycle with a fixed latency of W cycles.
module onehot_to_bin_pipe
  import onehot_to_bin_pipe_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  onehot_to_bin_pipe_if.slave  io
);

  // Level g handles fold index m = W-1-g, so data flows from g_lvl[0] to g_lvl[W-1].
  for (genvar g = 0; g < W; g++) begin : g_lvl
    localparam int M = W - 1 - g;
    localparam int H = fold_width(M);

    logic [2*H-1:0] vec_in;
    logic [W-1:0]   bin_in;
    logic           multi_in;
    logic           vld_in;
    logic [H-1:0]   vec_q;
    logic [W-1:0]   bin_q;
    logic           multi_q;
    logic           vld_q;

    if (g == 0) begin : g_first
      assign vec_in   = io.onehot;
      assign bin_in   = '0;
      assign multi_in = 1'b0;
      assign vld_in   = io.in_vld;
    end else begin : g_next
      assign vec_in   = g_lvl[g-1].vec_q;
      assign bin_in   = g_lvl[g-1].bin_q;
      assign multi_in = g_lvl[g-1].multi_q;
      assign vld_in   = g_lvl[g-1].vld_q;
    end

    onehot_fold_stage #(
      .M (M),
      .W (W)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .vec     (vec_in),
      .bin     (bin_in),
      .multi   (multi_in),
      .vld     (vld_in),
      .vec_q   (vec_q),
      .bin_q   (bin_q),
      .multi_q (multi_q),
      .vld_q   (vld_q)
    );
  end

  logic last_vld;
  logic last_bad;

  assign last_vld = g_lvl[W-1].vld_q;
  assign last_bad = ~g_lvl[W-1].vec_q[0] | g_lvl[W-1].multi_q;

  // Outputs are gated by the valid chain so idle cycles always read as zero.
  always_comb begin
    io.out_vld = last_vld;
    io.err     = last_vld & last_bad;
    io.bin     = (last_vld && !last_bad) ? g_lvl[W-1].bin_q : '0;
  end

endmodule

// File: tb/tb_onehot_to_bin_pipe.sv
// Directed bench for onehot_to_bin_pipe at W=4, W=1 and W=8.
module tb_onehot_to_bin_pipe;
  import onehot_to_bin_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  onehot_to_bin_pipe_if #(.W(4)) bus4 ();
  onehot_to_bin_pipe_if #(.W(1)) bus1 ();
  onehot_to_bin_pipe_if #(.W(8)) bus8 ();

  onehot_to_bin_pipe #(.W(4)) u_dut4 (.clk(clk), .rst(rst), .io(bus4.slave));
  onehot_to_bin_pipe #(.W(1)) u_dut1 (.clk(clk), .rst(rst), .io(bus1.slave));
  onehot_to_bin_pipe #(.W(8)) u_dut8 (.clk(clk), .rst(rst), .io(bus8.slave));

  logic [3:0]   sh4_bin;
  logic [15:0]  sh4_oh;
  logic [0:0]   sh1_bin;
  logic [1:0]   sh1_oh;
  logic [7:0]   sh8_bin;
  logic [255:0] sh8_oh;

  bin_to_onehot_shift #(.W(4)) u_sh4 (.bin(sh4_bin), .onehot(sh4_oh));
  bin_to_onehot_shift #(.W(1)) u_sh1 (.bin(sh1_bin), .onehot(sh1_oh));
  bin_to_onehot_shift #(.W(8)) u_sh8 (.bin(sh8_bin), .onehot(sh8_oh));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Expected W=4 pipeline contents; index 3 is what the outputs should show.
  logic       m_vld [4];
  logic [3:0] m_bin [4];
  logic       m_err [4];

  task automatic clear_model();
    for (int k = 0; k < 4; k++) begin
      m_vld[k] = 1'b0;
      m_bin[k] = '0;
      m_err[k] = 1'b0;
    end
  endtask

  // Called at a falling edge: drive one input, clock it in, then check outputs.
  task automatic tick(input string tag, input logic vld, input logic [15:0] oh,
                      input logic [3:0] ebin, input logic eerr);
    bus4.in_vld = vld;
    bus4.onehot = oh;
    @(posedge clk);
    for (int k = 3; k > 0; k--) begin
      m_vld[k] = m_vld[k-1];
      m_bin[k] = m_bin[k-1];
      m_err[k] = m_err[k-1];
    end
    m_vld[0] = vld;
    m_bin[0] = (vld && !eerr) ? ebin : 4'd0;
    m_err[0] = vld & eerr;
    @(negedge clk);
    check_val({tag, ".out_vld"}, 32'(bus4.out_vld), 32'(m_vld[3]));
    check_val({tag, ".bin"},     32'(bus4.bin),     32'(m_bin[3]));
    check_val({tag, ".err"},     32'(bus4.err),     32'(m_err[3]));
  endtask

  task automatic idle4(input string tag, input int n);
    for (int k = 0; k < n; k++) tick(tag, 1'b0, 16'hFFFF, 4'd0, 1'b0);
  endtask

  initial begin
    rst         = 1'b1;
    bus4.in_vld = 1'b0;
    bus4.onehot = '0;
    bus1.in_vld = 1'b0;
    bus1.onehot = '0;
    bus8.in_vld = 1'b0;
    bus8.onehot = '0;
    sh4_bin     = '0;
    sh1_bin     = '0;
    sh8_bin     = '0;
    clear_model();

    repeat (2) @(negedge clk);
    check_val("rst.out_vld", 32'(bus4.out_vld), 32'd0);
    check_val("rst.bin",     32'(bus4.bin),     32'd0);
    check_val("rst.err",     32'(bus4.err),     32'd0);
    rst = 1'b0;

    // Sweep every legal one-hot code back to back.
    for (int i = 0; i < 16; i++) begin
      sh4_bin = 4'(i);
      #1;
      tick("sweep", 1'b1, sh4_oh, 4'(i), 1'b0);
    end
    idle4("sweep_drain", 4);

    tick("zero",  1'b1, 16'h0000, 4'd0,  1'b1);
    tick("m0101", 1'b1, 16'h0101, 4'd0,  1'b1);
    tick("m8001", 1'b1, 16'h8001, 4'd0,  1'b1);
    tick("mffff", 1'b1, 16'hFFFF, 4'd0,  1'b1);
    tick("after", 1'b1, 16'h0400, 4'd10, 1'b0);
    idle4("err_drain", 4);

    tick("bub3",  1'b1, 16'h0008, 4'd3,  1'b0);
    tick("bub_a", 1'b0, 16'hFFFF, 4'd0,  1'b0);
    tick("bub12", 1'b1, 16'h1000, 4'd12, 1'b0);
    tick("bub_b", 1'b0, 16'h0000, 4'd0,  1'b0);
    idle4("bub_drain", 4);

    // Reset with the first item on the output and three more in flight.
    tick("pre1", 1'b1, 16'h0002, 4'd1, 1'b0);
    tick("pre2", 1'b1, 16'h0004, 4'd2, 1'b0);
    tick("pre5", 1'b1, 16'h0020, 4'd5, 1'b0);
    tick("pre9", 1'b1, 16'h0200, 4'd9, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_val("async_rst.out_vld", 32'(bus4.out_vld), 32'd0);
    check_val("async_rst.bin",     32'(bus4.bin),     32'd0);
    check_val("async_rst.err",     32'(bus4.err),     32'd0);
    bus4.in_vld = 1'b1;
    bus4.onehot = 16'h0040;
    @(negedge clk);
    check_val("held_rst.out_vld", 32'(bus4.out_vld), 32'd0);
    rst = 1'b0;
    clear_model();
    tick("post7", 1'b1, 16'h0080, 4'd7, 1'b0);
    idle4("post_drain", 5);

    // W=1: latency of one cycle.
    sh1_bin     = 1'b0;
    #1;
    bus1.in_vld = 1'b1;
    bus1.onehot = sh1_oh;
    @(negedge clk);
    check_val("w1_b01.out_vld", 32'(bus1.out_vld), 32'd1);
    check_val("w1_b01.bin",     32'(bus1.bin),     32'd0);
    check_val("w1_b01.err",     32'(bus1.err),     32'd0);
    sh1_bin     = 1'b1;
    #1;
    bus1.onehot = sh1_oh;
    @(negedge clk);
    check_val("w1_b10.out_vld", 32'(bus1.out_vld), 32'd1);
    check_val("w1_b10.bin",     32'(bus1.bin),     32'd1);
    check_val("w1_b10.err",     32'(bus1.err),     32'd0);
    bus1.onehot = 2'b11;
    @(negedge clk);
    check_val("w1_b11.bin", 32'(bus1.bin), 32'd0);
    check_val("w1_b11.err", 32'(bus1.err), 32'd1);
    bus1.in_vld = 1'b0;
    @(negedge clk);
    check_val("w1_idle.out_vld", 32'(bus1.out_vld), 32'd0);

    // W=8: one item, visible only on the eighth cycle.
    sh8_bin     = 8'd200;
    #1;
    bus8.in_vld = 1'b1;
    bus8.onehot = sh8_oh;
    @(posedge clk);
    #1;
    bus8.in_vld = 1'b0;
    bus8.onehot = '0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check_val($sformatf("w8_c%0d.out_vld", k), 32'(bus8.out_vld), 32'(k == 8));
      if (k == 8) begin
        check_val("w8.bin", 32'(bus8.bin), 32'd200);
        check_val("w8.err", 32'(bus8.err), 32'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
